uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_rx_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: synchronises the receiver's frame-ready strobe, checks
// framing and parity, and queues good bytes in a small FIFO with sticky error tracking.
module uart_rx_ctrl #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  output logic                     Rx_EN,
  input  logic                     Rx_valid,
  input  logic [10:0]              rx_frame,
  input  logic                     Rx_FERROR,
  output logic [7:0]               out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     err_parity,
  output logic                     err_frame,
  output logic                     err_overflow,
  input  logic                     clr_err,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam logic        PAR = PARITY_ODD[0];

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    CHECK
  } state_t;

  state_t state, state_n;

  logic          s1, s2, s3;
  logic          rx_evt;
  logic          capture;
  logic [10:0]   hold_frame;
  logic          hold_ferr;

  logic          in_check;
  logic          frame_ok, parity_ok;
  logic          good, full, pop, push;
  logic          set_frame, set_parity, set_ovf, drop;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  // Rx_valid is asynchronous: two sync flops, then a history flop for edge detect
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= Rx_valid;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rx_evt = s2 & ~s3;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    Rx_EN   = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_n = ARMED;
      end
      ARMED: begin
        Rx_EN = 1'b1;
        if (rx_evt) begin
          capture = 1'b1;
          state_n = CHECK;
        end else if (!enable) begin
          state_n = IDLE;
        end
      end
      CHECK: begin
        state_n = enable ? ARMED : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_frame <= '0;
      hold_ferr  <= 1'b0;
    end else if (capture) begin
      hold_frame <= rx_frame;
      hold_ferr  <= Rx_FERROR;
    end
  end

  assign in_check  = (state == CHECK);
  assign frame_ok  = ~hold_frame[0] & hold_frame[10] & ~hold_ferr;
  assign parity_ok = ((^hold_frame[9:1]) == PAR);

  assign full = (count == CW'(DEPTH));
  assign pop  = out_valid & out_ready;
  assign good = in_check & frame_ok & parity_ok;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = good & (~full | pop);

  assign set_frame  = in_check & ~frame_ok;
  assign set_parity = in_check & frame_ok & ~parity_ok;
  assign set_ovf    = good & full & ~pop;
  assign drop       = set_frame | set_parity | set_ovf;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= hold_frame[8:1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // A new error in the same cycle as clr_err survives the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      err_frame    <= 1'b0;
      err_parity   <= 1'b0;
      err_overflow <= 1'b0;
      drop_cnt     <= '0;
    end else begin
      err_frame    <= set_frame  | (err_frame    & ~clr_err);
      err_parity   <= set_parity | (err_parity   & ~clr_err);
      err_overflow <= set_ovf    | (err_overflow & ~clr_err);
      if (drop) begin
        if (clr_err)              drop_cnt <= 8'd1;
        else if (drop_cnt != '1)  drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_err) begin
        drop_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frames are driven through the async strobe,
// expected bytes queued on send and compared as they leave the FIFO.
module tb_uart_rx_ctrl;

  logic        clk = 1'b0;
  logic        reset, enable, Rx_EN, Rx_valid, Rx_FERROR;
  logic [10:0] rx_frame;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic [2:0]  fifo_count;
  logic        err_parity, err_frame, err_overflow, clr_err;
  logic [7:0]  drop_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [7:0]  sb_q[$];

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(4), .PARITY_ODD(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .Rx_EN(Rx_EN),
    .Rx_valid(Rx_valid), .rx_frame(rx_frame), .Rx_FERROR(Rx_FERROR),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .err_parity(err_parity), .err_frame(err_frame),
    .err_overflow(err_overflow), .clr_err(clr_err), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // rdy/clr/dis act during the CHECK cycle (between the 3rd and 4th edge)
  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit,
                            input logic ferr, input logic rdy, input logic clr, input logic dis);
    rx_frame  = {stop_bit, (^d) ^ par_flip, d, 1'b0};
    Rx_FERROR = ferr;
    Rx_valid  = 1'b1;
    tick();
    tick();
    tick();
    if (rdy) begin
      out_ready = 1'b1;
      chk("pop_in_check", out_data, sb_q.pop_front());
    end
    if (clr) clr_err = 1'b1;
    if (dis) enable = 1'b0;
    tick();
    out_ready = 1'b0;
    clr_err   = 1'b0;
    Rx_valid  = 1'b0;
    Rx_FERROR = 1'b0;
    repeat (3) tick();
  endtask

  task automatic drain();
    int unsigned n = 0;
    out_ready = 1'b1;
    while (sb_q.size() > 0 && n < 20) begin
      if (out_valid) chk("drain_data", out_data, sb_q.pop_front());
      tick();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_left", sb_q.size(), 0);
    chk("drain_empty", out_valid, 1'b0);
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_flags", {err_parity, err_frame, err_overflow}, 3'b000);
    chk("clr_drop", drop_cnt, 8'd0);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; Rx_valid = 1'b0; rx_frame = '0; Rx_FERROR = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) tick();
    chk("rst_rx_en", Rx_EN, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_count", fifo_count, 3'd0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_flags", {err_parity, err_frame, err_overflow}, 3'b000);
    chk("rst_drop", drop_cnt, 8'd0);
    reset = 1'b0;
    tick();
    chk("armed_rx_en", Rx_EN, 1'b1);

    // Good frame 0xA5: latency from first sampling edge to out_valid
    rx_frame = 11'b1_0_1010_0101_0;
    Rx_valid = 1'b1;
    sb_q.push_back(8'hA5);
    tick(); chk("lat_e1", out_valid, 1'b0);
    tick(); chk("lat_e2", out_valid, 1'b0);
    tick(); chk("lat_e3", out_valid, 1'b0);
    tick(); chk("lat_e4", out_valid, 1'b1);
    Rx_valid = 1'b0;
    repeat (3) tick();
    chk("a5_data", out_data, 8'hA5);
    chk("a5_count", fifo_count, 3'd1);
    chk("a5_flags", {err_parity, err_frame, err_overflow}, 3'b000);
    chk("a5_stable", out_data, 8'hA5);
    drain();

    // Parity error
    send_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("par_err", err_parity, 1'b1);
    chk("par_drop", drop_cnt, 8'd1);
    chk("par_nopush", out_valid, 1'b0);
    clear_errs();

    // Framing errors: stop bit low, then receiver FERROR
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stop_err", err_frame, 1'b1);
    chk("stop_par", err_parity, 1'b0);
    chk("stop_nopush", out_valid, 1'b0);
    clear_errs();
    send_frame(8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ferr_err", err_frame, 1'b1);
    chk("ferr_count", fifo_count, 3'd0);
    chk("ferr_drop", drop_cnt, 8'd1);
    clear_errs();

    // Overflow: five good frames into a depth-4 FIFO with no consumer
    for (int i = 0; i < 5; i++) begin
      if (i < 4) sb_q.push_back(8'h10 + 8'(i));
      send_frame(8'h10 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("ovf_count", fifo_count, 3'd4);
    chk("ovf_flag", err_overflow, 1'b1);
    chk("ovf_drop", drop_cnt, 8'd1);
    drain();
    clear_errs();

    // Full FIFO with pop in the CHECK cycle accepts the new byte
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'hC0 + 8'(i));
      send_frame(8'hC0 + 8'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("full_count", fifo_count, 3'd4);
    send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sb_q.push_back(8'h5A);
    chk("pp_count", fifo_count, 3'd4);
    chk("pp_ovf", err_overflow, 1'b0);
    chk("pp_drop", drop_cnt, 8'd0);
    drain();

    // Error set and clr_err together: set wins
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("setwin_flag", err_frame, 1'b1);
    chk("setwin_drop", drop_cnt, 8'd1);
    clear_errs();

    // drop_cnt saturation
    for (int i = 0; i < 257; i++)
      send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("sat_drop", drop_cnt, 8'd255);
    clear_errs();

    // enable drops during CHECK: the frame is still pushed
    sb_q.push_back(8'h81);
    send_frame(8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("dis_rx_en", Rx_EN, 1'b0);
    chk("dis_push", fifo_count, 3'd1);
    chk("dis_data", out_data, sb_q[0]);
    enable = 1'b1;
    tick();
    chk("reen_rx_en", Rx_EN, 1'b1);

    // Reset one cycle after a strobe rise discards everything
    sb_q.delete();
    rx_frame = 11'b1_0_1010_0101_0;
    Rx_valid = 1'b1;
    tick();
    reset = 1'b1;
    Rx_valid = 1'b0;
    tick();
    chk("rst2_rx_en", Rx_EN, 1'b0);
    chk("rst2_valid", out_valid, 1'b0);
    chk("rst2_count", fifo_count, 3'd0);
    chk("rst2_flags", {err_parity, err_frame, err_overflow}, 3'b000);
    chk("rst2_drop", drop_cnt, 8'd0);
    reset = 1'b0;
    chk("rst2_idle", Rx_EN, 1'b0);
    tick();
    chk("rst2_armed", Rx_EN, 1'b1);
    repeat (5) tick();
    chk("rst2_nopush", out_valid, 1'b0);
    chk("rst2_noflag", {err_parity, err_frame, err_overflow}, 3'b000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
